// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding-read memory handshake, redirect
// handling, a one-entry skid register for decode stalls, and the IF/ID register.
module fetch #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(32'h0000_0000)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  input  logic                     stall_d,
  input  logic                     flush_d,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic                     valid_f
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_KILL = 2'd3;

  localparam logic [DATA_WIDTH-1:0]    NOP    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] PC_INC = ADDRESS_WIDTH'(4);

  logic [1:0]               state, state_nx;
  logic [ADDRESS_WIDTH-1:0] pc, pc_nx, pc_plus4;
  logic                     skid_ld, resp_ld, skid_out_ld;
  logic [DATA_WIDTH-1:0]    skid_instr;
  logic [ADDRESS_WIDTH-1:0] skid_pc, skid_pc4;
  logic [DATA_WIDTH-1:0]    instr_nx;
  logic [ADDRESS_WIDTH-1:0] pcf_nx, pc4f_nx;
  logic                     valid_nx;

  assign pc_plus4  = pc + PC_INC;
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nx;
  end

  // Next state, PC update and load strobes; a redirect always wins over a response
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    skid_ld     = 1'b0;
    resp_ld     = 1'b0;
    skid_out_ld = 1'b0;
    imem_req    = 1'b0;
    case (state)
      S_REQ: begin
        if (pc_src_e) begin
          pc_nx = pc_target_e;
        end else begin
          imem_req = rst_n;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pc_src_e) begin
          pc_nx    = pc_target_e;
          state_nx = imem_rvalid ? S_REQ : S_KILL;
        end else if (imem_rvalid) begin
          pc_nx = pc_plus4;
          if (stall_d) begin
            skid_ld  = 1'b1;
            state_nx = S_HOLD;
          end else begin
            resp_ld  = ~flush_d;
            state_nx = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (pc_src_e) begin
          pc_nx    = pc_target_e;
          state_nx = S_REQ;
        end else if (!stall_d) begin
          skid_out_ld = ~flush_d;
          state_nx    = S_REQ;
        end
      end
      S_KILL: begin
        if (pc_src_e) pc_nx = pc_target_e;
        if (imem_rvalid) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  // IF/ID next value: flush beats stall beats load; otherwise a bubble
  always_comb begin
    instr_nx = instr_f;
    pcf_nx   = pc_f;
    pc4f_nx  = pc_plus4_f;
    valid_nx = valid_f;
    if (flush_d) begin
      instr_nx = NOP;
      valid_nx = 1'b0;
    end else if (!stall_d) begin
      if (resp_ld) begin
        instr_nx = imem_rdata;
        pcf_nx   = pc;
        pc4f_nx  = pc_plus4;
        valid_nx = 1'b1;
      end else if (skid_out_ld) begin
        instr_nx = skid_instr;
        pcf_nx   = skid_pc;
        pc4f_nx  = skid_pc4;
        valid_nx = 1'b1;
      end else begin
        instr_nx = NOP;
        valid_nx = 1'b0;
      end
    end
  end

  // PC, skid entry and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      skid_instr <= NOP;
      skid_pc    <= '0;
      skid_pc4   <= '0;
      instr_f    <= NOP;
      pc_f       <= '0;
      pc_plus4_f <= '0;
      valid_f    <= 1'b0;
    end else begin
      pc <= pc_nx;
      if (skid_ld) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
        skid_pc4   <= pc_plus4;
      end
      instr_f    <= instr_nx;
      pc_f       <= pcf_nx;
      pc_plus4_f <= pc4f_nx;
      valid_f    <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a cycle table for the main flow plus hand sequences
// for redirect-while-waiting, PC wrap and reset during a held response.
module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        stall_d;
  logic        flush_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        valid_f;

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .stall_d(stall_d), .flush_d(flush_d), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_f(instr_f),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .valid_f(valid_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory model: answers a request mem_lat cycles later, reset with the DUT
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      cnt         <= 0;
      paddr       <= '0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= instr_at(paddr);
          pend        <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req) begin
        if (mem_lat == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= instr_at(imem_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= mem_lat - 1;
          paddr <= imem_addr;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                          input logic [31:0] e4, input logic ev);
    chk({tag, " instr_f"}, instr_f, ei);
    chk({tag, " pc_f"}, pc_f, ep);
    chk({tag, " pc_plus4_f"}, pc_plus4_f, e4);
    chk({tag, " valid_f"}, 32'(valid_f), 32'(ev));
  endtask

  task automatic drv(input logic s, input logic [31:0] t, input logic st, input logic fl);
    pc_src_e    = s;
    pc_target_e = t;
    stall_d     = st;
    flush_d     = fl;
    #1;
  endtask

  // Ends at a negedge with rst_n just released: the caller's next drive is cycle 1
  task automatic do_reset(input int lat);
    mem_lat = lat;
    rst_n   = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset imem_req", 32'(imem_req), 32'h0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk_ifid("reset", NOP, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        pc_src;
    logic [31:0] tgt;
    logic        stall;
    logic        flush;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Per cycle: inputs, then expected imem_req/imem_addr and current IF/ID
    vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h000, NOP,          32'h000, 32'h000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h000, NOP,          32'h000, 32'h000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h004, 32'h00500093, 32'h000, 32'h004, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h004, NOP,          32'h000, 32'h004, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h008, 32'hC0DE0004, 32'h004, 32'h008, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h008, 32'hC0DE0004, 32'h004, 32'h008, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h00C, 32'hC0DE0004, 32'h004, 32'h008, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h00C, 32'hC0DE0004, 32'h004, 32'h008, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h00C, 32'hC0DE0008, 32'h008, 32'h00C, 1'b1};
    vecs[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h00C, NOP,          32'h008, 32'h00C, 1'b0};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100, NOP,          32'h008, 32'h00C, 1'b0};
    vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h100, NOP,          32'h008, 32'h00C, 1'b0};
    vecs[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h104, 32'hC0DE0100, 32'h100, 32'h104, 1'b1};
    vecs[13] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h104, NOP,          32'h100, 32'h104, 1'b0};
    vecs[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h108, NOP,          32'h100, 32'h104, 1'b0};

    // Main flow: reset, stall into skid, flush+stall, redirect on response, flush discard
    do_reset(1);
    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drv(vecs[i].pc_src, vecs[i].tgt, vecs[i].stall, vecs[i].flush);
      chk({tag, " imem_req"}, 32'(imem_req), 32'(vecs[i].e_req));
      chk({tag, " imem_addr"}, imem_addr, vecs[i].e_addr);
      chk_ifid(tag, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_valid);
      @(negedge clk);
    end

    // Redirect while waiting with a 2-cycle memory: stale response is dropped in KILL
    do_reset(2);
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("kill c1 imem_req", 32'(imem_req), 32'h1);
    @(negedge clk);
    drv(1'b1, 32'h100, 1'b0, 1'b0);
    chk("kill c2 imem_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("kill c3 imem_req", 32'(imem_req), 32'h0);
    chk("kill c3 imem_addr", imem_addr, 32'h100);
    chk("kill c3 valid_f", 32'(valid_f), 32'h0);
    @(negedge clk);
    chk("kill c4 imem_req", 32'(imem_req), 32'h1);
    chk("kill c4 imem_addr", imem_addr, 32'h100);
    chk("kill c4 valid_f", 32'(valid_f), 32'h0);
    @(negedge clk);
    chk("kill c5 valid_f", 32'(valid_f), 32'h0);
    @(negedge clk);
    chk("kill c6 valid_f", 32'(valid_f), 32'h0);
    @(negedge clk);
    chk_ifid("kill c7", 32'hC0DE0100, 32'h100, 32'h104, 1'b1);

    // PC+4 wraps silently at the top of the address space
    @(negedge clk);
    do_reset(1);
    drv(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("wrap c1 imem_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap c2 imem_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    chk_ifid("wrap c4", 32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk("wrap c4 imem_addr", imem_addr, 32'h0);
    chk("wrap c4 imem_req", 32'(imem_req), 32'h1);

    // Reset asserted in HOLD with a full skid entry: immediate reset values, entry lost
    @(negedge clk);
    do_reset(1);
    drv(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("hold imem_req", 32'(imem_req), 32'h0);
    chk("hold imem_addr", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("hold rst imem_req", 32'(imem_req), 32'h0);
    chk("hold rst imem_addr", imem_addr, 32'h0);
    chk_ifid("hold rst", NOP, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("hold rel c1 imem_req", 32'(imem_req), 32'h1);
    chk("hold rel c1 imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("hold rel c2 valid_f", 32'(valid_f), 32'h0);
    @(negedge clk);
    chk_ifid("hold rel c3", 32'h0050_0093, 32'h0, 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
